// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW stall/bubble controller beside the ID stage.
// Keeps its own shadow of the EXE/MEM/WB destinations, rebuilt from the ID
// inputs, and raises hazard/bubble when an ID source depends on an in-flight
// write that cannot yet be supplied.
module hazard_ctrl #(
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 16,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              forward_en,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic [ADDR_W-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  output logic              hazard,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              v;
    logic              wb;
    logic              ld;
    logic [ADDR_W-1:0] dest;
  } sb_entry_t;

  sb_entry_t r_exe;
  sb_entry_t r_mem;
  sb_entry_t r_wb;
  logic [CNT_W-1:0] r_stall_count;

  logic w_issue;
  logic w_exe_hit;
  logic w_mem_hit;
  logic w_wb_hit;
  logic w_hazard;

  // Register 0 is hardwired, so it never carries a dependency.
  function automatic logic f_match(input logic [ADDR_W-1:0] s, input sb_entry_t e);
    return e.v & e.wb & (s != '0) & (s == e.dest);
  endfunction

  // Source-vs-scoreboard compares and the resulting stall decision.
  always_comb begin
    w_exe_hit = f_match(id_src1, r_exe) | (id_two_src & f_match(id_src2, r_exe));
    w_mem_hit = f_match(id_src1, r_mem) | (id_two_src & f_match(id_src2, r_mem));
    w_wb_hit  = f_match(id_src1, r_wb)  | (id_two_src & f_match(id_src2, r_wb));
    w_hazard  = 1'b0;
    if (id_valid && !rst) begin
      if (forward_en) begin
        // Forwarding covers everything except a load whose data is not back yet.
        w_hazard = w_exe_hit & r_exe.ld;
      end else begin
        w_hazard = w_exe_hit | w_mem_hit | (!WB_BYPASS && w_wb_hit);
      end
    end
  end

  assign w_issue = id_valid & ~w_hazard;

  // Scoreboard advances every cycle; a stalled slot enters EXE as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exe <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_exe;
      r_exe <= '{v: w_issue, wb: id_wb_en & w_issue, ld: id_mem_r_en & w_issue, dest: id_dest};
    end
  end

  // Saturating count of hazard cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_hazard && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign hazard      = w_hazard;
  assign bubble      = w_hazard;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: three configurations driven by one shared stimulus stream.
//   dut_a: defaults, dut_b: CNT_W=2 (saturation), dut_c: WB_BYPASS=0.
// The reference model tracks in-flight writers by age (cycles since issue).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       forward_en;
  logic       id_valid;
  logic [4:0] id_src1;
  logic [4:0] id_src2;
  logic       id_two_src;
  logic [4:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_r_en;

  logic        haz_a, bub_a, haz_b, bub_b, haz_c, bub_c;
  logic [15:0] cnt_a, cnt_c;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .hazard(haz_a), .bubble(bub_a), .stall_count(cnt_a)
  );

  hazard_ctrl #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .hazard(haz_b), .bubble(bub_b), .stall_count(cnt_b)
  );

  hazard_ctrl #(.WB_BYPASS(1'b0)) dut_c (
    .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .hazard(haz_c), .bubble(bub_c), .stall_count(cnt_c)
  );

  // In-flight writer: age 1 = in EXE, 2 = MEM, 3 = WB.
  typedef struct {
    int       age;
    logic     ld;
    logic [4:0] dest;
  } writer_t;

  typedef struct {
    logic     haz_ab;
    int       cnt_a;
    int       cnt_b;
    logic     haz_c;
    int       cnt_c;
  } exp_t;

  writer_t hist_ab[$];
  writer_t hist_c[$];
  exp_t    exp_q[$];
  int      m_cnt_a = 0, m_cnt_b = 0, m_cnt_c = 0;
  int      n_tests = 0, n_fail = 0;

  function automatic logic model_haz(input writer_t h[$], input logic bypass);
    logic hit = 1'b0;
    if (rst || !id_valid) return 1'b0;
    foreach (h[i]) begin
      if (h[i].dest != 0 && (h[i].dest == id_src1 || (id_two_src && h[i].dest == id_src2))) begin
        if (forward_en) begin
          if (h[i].age == 1 && h[i].ld) hit = 1'b1;
        end else if (h[i].age <= 2 || (h[i].age == 3 && !bypass)) begin
          hit = 1'b1;
        end
      end
    end
    return hit;
  endfunction

  function automatic void advance(ref writer_t h[$], input logic haz);
    writer_t nh[$];
    writer_t w;
    foreach (h[i]) begin
      w = h[i];
      w.age = w.age + 1;
      if (w.age <= 3) nh.push_back(w);
    end
    if (id_valid && !haz && id_wb_en) begin
      w.age = 1; w.ld = id_mem_r_en; w.dest = id_dest;
      nh.push_back(w);
    end
    h = nh;
  endfunction

  // One cycle of stimulus: drive, predict this cycle's outputs, step the model.
  task automatic drive(input logic r, input logic f, input logic v, input logic [4:0] s1,
                       input logic [4:0] s2, input logic two, input logic [4:0] d,
                       input logic w, input logic l);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; forward_en = f; id_valid = v; id_src1 = s1; id_src2 = s2;
    id_two_src = two; id_dest = d; id_wb_en = w; id_mem_r_en = l;
    e.haz_ab = model_haz(hist_ab, 1'b1);
    e.haz_c  = model_haz(hist_c, 1'b0);
    e.cnt_a = m_cnt_a; e.cnt_b = m_cnt_b; e.cnt_c = m_cnt_c;
    exp_q.push_back(e);
    if (r) begin
      hist_ab.delete(); hist_c.delete();
      m_cnt_a = 0; m_cnt_b = 0; m_cnt_c = 0;
    end else begin
      if (e.haz_ab) begin
        if (m_cnt_a < 65535) m_cnt_a++;
        if (m_cnt_b < 3) m_cnt_b++;
      end
      if (e.haz_c && m_cnt_c < 65535) m_cnt_c++;
      advance(hist_ab, e.haz_ab);
      advance(hist_c, e.haz_c);
    end
  endtask

  task automatic idle();
    drive(1'b0, forward_en, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares every presented cycle against the queued prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("hazard_a", int'(haz_a), int'(e.haz_ab));
      check("bubble_a", int'(bub_a), int'(e.haz_ab));
      check("count_a",  int'(cnt_a), e.cnt_a);
      check("hazard_b", int'(haz_b), int'(e.haz_ab));
      check("count_b",  int'(cnt_b), e.cnt_b);
      check("hazard_c", int'(haz_c), int'(e.haz_c));
      check("bubble_c", int'(bub_c), int'(e.haz_c));
      check("count_c",  int'(cnt_c), e.cnt_c);
    end
  end

  initial begin
    rst = 1'b1; forward_en = 1'b0; id_valid = 1'b0; id_src1 = '0; id_src2 = '0;
    id_two_src = 1'b0; id_dest = '0; id_wb_en = 1'b0; id_mem_r_en = 1'b0;
    // Reset, then quiet cycles.
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    repeat (3) idle();
    // Load-use with forwarding: load r3, ADD reads r3 (held until issued).
    drive(0, 1, 1, 5'd1, 5'd2, 1, 5'd3, 1, 1);
    repeat (2) drive(0, 1, 1, 5'd3, 5'd4, 1, 5'd6, 1, 0);
    repeat (4) idle();
    // No forwarding: ADD r5, SUB reads r5 via src2 (two-src then one-src).
    drive(0, 0, 1, 5'd1, 5'd2, 1, 5'd5, 1, 0);
    repeat (4) drive(0, 0, 1, 5'd7, 5'd5, 1, 5'd8, 1, 0);
    repeat (4) idle();
    drive(0, 0, 1, 5'd1, 5'd2, 1, 5'd5, 1, 0);
    drive(0, 0, 1, 5'd7, 5'd5, 0, 5'd8, 1, 0);
    repeat (4) idle();
    // Writer to r0 never causes a hazard.
    for (int f = 0; f < 2; f++) begin
      drive(0, f[0], 1, 5'd1, 5'd2, 1, 5'd0, 1, 1);
      drive(0, f[0], 1, 5'd0, 5'd0, 1, 5'd9, 1, 0);
      repeat (3) idle();
    end
    // Reset pulsed mid-stall, then the reader re-issues cleanly.
    drive(0, 0, 1, 5'd1, 5'd2, 1, 5'd4, 1, 0);
    drive(0, 0, 1, 5'd4, 5'd0, 0, 5'd10, 1, 0);
    drive(1, 0, 1, 5'd4, 5'd0, 0, 5'd10, 1, 0);
    drive(0, 0, 1, 5'd4, 5'd0, 0, 5'd10, 1, 0);
    repeat (3) idle();
    // Dependent pairs without forwarding to saturate the 2-bit counter.
    repeat (3) begin
      drive(0, 0, 1, 5'd1, 5'd2, 1, 5'd11, 1, 0);
      repeat (4) drive(0, 0, 1, 5'd11, 5'd0, 0, 5'd12, 1, 0);
    end
    repeat (4) idle();
    // Random traffic over a small register set to provoke frequent hazards.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0) ? ~forward_en : forward_en,
            ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
            1'($urandom), 5'($urandom_range(0, 4)), ($urandom_range(0, 3) != 0), 1'($urandom));
    end
    idle();
    @(posedge clk);
    @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
